execute_div_unit: RTL

//  Iterative restoring divider for the execute stage, directly downstream of decode_stage.
//  - Consumes has_div_d, plus the rs/rt values after the decode->execute pipeline register.
//  - Produces the HI (remainder) and LO (quotient) values, which are carried to writeback
//    as div_hi_w/div_lo_w with has_div_w.
//  - Drives busy to the hazard unit, which stalls fetch/decode until the result is ready.

---
 rtl/execute_div_unit_if.sv | 25 ++
 rtl/execute_div_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/execute_div_unit_if.sv
// Execute-stage divider handshake: request/operand signals in, busy/done/result out.
interface execute_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor, cancel,
        input  busy, done, div_hi, div_lo, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor, cancel,
        output busy, done, div_hi, div_lo, div_by_zero
    );
endinterface

// File: rtl/execute_div_unit.sv
// Iterative restoring divider (one quotient bit per cycle) for the execute stage.
// Operates on magnitudes and applies the DIV sign fix when the last bit is produced.
module execute_div_unit #(
    parameter int WIDTH = 32
) (
    input logic               clock,
    input logic               reset,
    execute_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_r;
    logic [1:0]       state_next_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] dvd_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic             dbz_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             dbz_out_r;

    logic             accept_s;
    logic             finish_s;
    logic [WIDTH-1:0] mag_dvd_s;
    logic [WIDTH-1:0] mag_dvs_s;
    logic [WIDTH+1:0] shifted_s;
    logic [WIDTH+1:0] diff_s;
    logic [WIDTH:0]   rem_next_s;
    logic             qbit_s;
    logic [WIDTH-1:0] quo_next_s;
    logic [WIDTH-1:0] fin_hi_s;
    logic [WIDTH-1:0] fin_lo_s;

    // Next-state logic; cancel only matters while an operation is running.
    always_comb begin
        state_next_s = IDLE;
        case (state_r)
            IDLE: begin
                if (bus.start) state_next_s = RUN;
                else           state_next_s = IDLE;
            end
            RUN: begin
                if (bus.cancel)              state_next_s = IDLE;
                else if (cnt_r == CW'(1))    state_next_s = DONE;
                else                         state_next_s = RUN;
            end
            DONE: begin
                if (bus.start) state_next_s = RUN;
                else           state_next_s = IDLE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    assign accept_s = ((state_r == IDLE) || (state_r == DONE)) && bus.start;
    assign finish_s = (state_r == RUN) && (state_next_s == DONE);

    // Operand magnitudes captured on accept (the most negative value stays as its unsigned bit pattern).
    always_comb begin
        if (bus.is_signed && bus.dividend[WIDTH-1]) mag_dvd_s = {WIDTH{1'b0}} - bus.dividend;
        else                                        mag_dvd_s = bus.dividend;
        if (bus.is_signed && bus.divisor[WIDTH-1])  mag_dvs_s = {WIDTH{1'b0}} - bus.divisor;
        else                                        mag_dvs_s = bus.divisor;
    end

    // One restoring step: shift in the next dividend bit, keep the difference if non-negative.
    always_comb begin
        shifted_s = {rem_r, quo_r[WIDTH-1]};
        diff_s    = shifted_s - {2'b00, dvs_r};
        if (diff_s[WIDTH+1]) begin
            rem_next_s = shifted_s[WIDTH:0];
            qbit_s     = 1'b0;
        end else begin
            rem_next_s = diff_s[WIDTH:0];
            qbit_s     = 1'b1;
        end
        quo_next_s = {quo_r[WIDTH-2:0], qbit_s};
    end

    // Final result with sign fix; a zero divisor bypasses it and reports the raw dividend.
    always_comb begin
        if (dbz_r) begin
            fin_lo_s = {WIDTH{1'b1}};
            fin_hi_s = dvd_r;
        end else begin
            if (neg_q_r) fin_lo_s = {WIDTH{1'b0}} - quo_next_s;
            else         fin_lo_s = quo_next_s;
            if (neg_r_r) fin_hi_s = {WIDTH{1'b0}} - rem_next_s[WIDTH-1:0];
            else         fin_hi_s = rem_next_s[WIDTH-1:0];
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            rem_r     <= {(WIDTH+1){1'b0}};
            quo_r     <= {WIDTH{1'b0}};
            dvs_r     <= {WIDTH{1'b0}};
            dvd_r     <= {WIDTH{1'b0}};
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            dbz_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            dbz_out_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == RUN);
            done_r  <= finish_s;
            if (accept_s) begin
                cnt_r   <= CW'(WIDTH);
                rem_r   <= {(WIDTH+1){1'b0}};
                quo_r   <= mag_dvd_s;
                dvs_r   <= mag_dvs_s;
                dvd_r   <= bus.dividend;
                neg_q_r <= bus.is_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                neg_r_r <= bus.is_signed && bus.dividend[WIDTH-1];
                dbz_r   <= (bus.divisor == {WIDTH{1'b0}});
            end else if ((state_r == RUN) && !bus.cancel) begin
                rem_r <= rem_next_s;
                quo_r <= quo_next_s;
                cnt_r <= cnt_r - CW'(1);
            end
            if (finish_s) begin
                hi_r      <= fin_hi_s;
                lo_r      <= fin_lo_s;
                dbz_out_r <= dbz_r;
            end
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_hi      = hi_r;
    assign bus.div_lo      = lo_r;
    assign bus.div_by_zero = dbz_out_r;
endmodule
